// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller.
package data_mem_ctrl_pkg;

  // Per-channel FSM state encoding
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } chan_state_e;

  // Width of an index able to address n items (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_channel.sv
// One memory channel: takes a granted consumer request, drives it onto the
// memory port, waits for the memory, then holds the consumer handshake until
// the consumer drops its valid.
module mem_ctrl_channel
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned IDX_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic                 grant_read,
  input  logic [IDX_BITS-1:0]  grant_idx,
  input  logic [ADDR_BITS-1:0] grant_addr,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 consumer_valid,
  input  logic                 mem_read_ready,
  input  logic                 mem_write_ready,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  output logic [IDX_BITS-1:0]  idx,
  output logic                 is_read,
  output logic                 idle_c,
  output logic                 read_done_c,
  output logic                 write_done_c,
  output logic                 release_c
);

  chan_state_e          state_q, state_d;
  logic                 rd_valid_d, wr_valid_d, is_read_d;
  logic [ADDR_BITS-1:0] rd_addr_d, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_d;
  logic [IDX_BITS-1:0]  idx_d;

  // State and registered memory-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      idx               <= '0;
      is_read           <= 1'b0;
    end else begin
      state_q           <= state_d;
      mem_read_valid    <= rd_valid_d;
      mem_read_address  <= rd_addr_d;
      mem_write_valid   <= wr_valid_d;
      mem_write_address <= wr_addr_d;
      mem_write_data    <= wr_data_d;
      idx               <= idx_d;
      is_read           <= is_read_d;
    end
  end

  // Next-state logic and consumer-side strobes
  always_comb begin
    state_d      = state_q;
    rd_valid_d   = mem_read_valid;
    rd_addr_d    = mem_read_address;
    wr_valid_d   = mem_write_valid;
    wr_addr_d    = mem_write_address;
    wr_data_d    = mem_write_data;
    idx_d        = idx;
    is_read_d    = is_read;
    read_done_c  = 1'b0;
    write_done_c = 1'b0;
    release_c    = 1'b0;
    idle_c       = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (grant) begin
          idx_d     = grant_idx;
          is_read_d = grant_read;
          if (grant_read) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = grant_addr;
            state_d    = READ_WAITING;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = grant_addr;
            wr_data_d  = grant_data;
            state_d    = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          rd_valid_d  = 1'b0;
          read_done_c = 1'b1;
          state_d     = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          wr_valid_d   = 1'b0;
          write_done_c = 1'b1;
          state_d      = WRITE_RELAYING;
        end
      end
      READ_RELAYING, WRITE_RELAYING: begin
        if (!consumer_valid) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/data_mem_controller.sv
// Data memory controller: arbitrates core LSU read/write requests onto
// NUM_CHANNELS memory channels and relays results back to the cores.
// Optional macro DATA_MEM_CTRL_RR_ARB_EN: round-robin search start instead of
// fixed lowest-index-first priority.
module data_mem_controller
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int unsigned IDX_BITS = idx_width(NUM_CONSUMERS);

  logic [ADDR_BITS-1:0]     rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     wr_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] serving;
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [IDX_BITS-1:0]      cand;
  int unsigned              start;

  logic [NUM_CHANNELS-1:0]  grant, grant_read;
  logic [NUM_CHANNELS-1:0]  chan_idle_c, chan_read_done_c, chan_write_done_c, chan_release_c;
  logic [NUM_CHANNELS-1:0]  chan_is_read, chan_valid;
  logic [IDX_BITS-1:0]      grant_idx [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      chan_idx  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     grant_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     grant_data [NUM_CHANNELS];

`ifdef DATA_MEM_CTRL_RR_ARB_EN
  logic [IDX_BITS-1:0]      rr_ptr, next_ptr;
`endif

  // Unflatten consumer request buses
  for (genvar j = 0; j < NUM_CONSUMERS; j++) begin : g_cons
    assign rd_addr[j] = consumer_read_address[j*ADDR_BITS +: ADDR_BITS];
    assign wr_addr[j] = consumer_write_address[j*ADDR_BITS +: ADDR_BITS];
    assign wr_data[j] = consumer_write_data[j*DATA_BITS +: DATA_BITS];
  end

  // Grant idle channels in ascending order; a claimed consumer is hidden from later channels
  always_comb begin
    grant      = '0;
    grant_read = '0;
    claimed    = '0;
    cand       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) grant_idx[c] = '0;
`ifdef DATA_MEM_CTRL_RR_ARB_EN
    start    = 32'(rr_ptr);
    next_ptr = rr_ptr;
`else
    start    = 0;
`endif
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
        cand = IDX_BITS'((start + k) % NUM_CONSUMERS);
        if (chan_idle_c[c] && !grant[c] && !serving[cand] && !claimed[cand] &&
            (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
          grant[c]      = 1'b1;
          grant_idx[c]  = cand;
          grant_read[c] = consumer_read_valid[cand];
          claimed[cand] = 1'b1;
`ifdef DATA_MEM_CTRL_RR_ARB_EN
          next_ptr      = IDX_BITS'((32'(cand) + 1) % NUM_CONSUMERS);
`endif
        end
      end
    end
  end

  // Channel instances with their request payload and handshake muxing
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign grant_addr[c] = grant_read[c] ? rd_addr[grant_idx[c]] : wr_addr[grant_idx[c]];
    assign grant_data[c] = wr_data[grant_idx[c]];
    assign chan_valid[c] = chan_is_read[c] ? consumer_read_valid[chan_idx[c]]
                                           : consumer_write_valid[chan_idx[c]];

    mem_ctrl_channel #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .IDX_BITS  (IDX_BITS)
    ) u_channel (
      .clk               (clk),
      .reset             (reset),
      .grant             (grant[c]),
      .grant_read        (grant_read[c]),
      .grant_idx         (grant_idx[c]),
      .grant_addr        (grant_addr[c]),
      .grant_data        (grant_data[c]),
      .consumer_valid    (chan_valid[c]),
      .mem_read_ready    (mem_read_ready[c]),
      .mem_write_ready   (mem_write_ready[c]),
      .mem_read_valid    (mem_read_valid[c]),
      .mem_read_address  (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_write_valid   (mem_write_valid[c]),
      .mem_write_address (mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_write_data    (mem_write_data[c*DATA_BITS +: DATA_BITS]),
      .idx               (chan_idx[c]),
      .is_read           (chan_is_read[c]),
      .idle_c            (chan_idle_c[c]),
      .read_done_c       (chan_read_done_c[c]),
      .write_done_c      (chan_write_done_c[c]),
      .release_c         (chan_release_c[c])
    );
  end

  // Serving mask, consumer handshakes and returned read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serving              <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (grant[c]) serving[grant_idx[c]] <= 1'b1;
        if (chan_read_done_c[c]) begin
          consumer_read_ready[chan_idx[c]] <= 1'b1;
          consumer_read_data[chan_idx[c]*DATA_BITS +: DATA_BITS] <=
            mem_read_data[c*DATA_BITS +: DATA_BITS];
        end
        if (chan_write_done_c[c]) consumer_write_ready[chan_idx[c]] <= 1'b1;
        if (chan_release_c[c]) begin
          serving[chan_idx[c]]              <= 1'b0;
          consumer_read_ready[chan_idx[c]]  <= 1'b0;
          consumer_write_ready[chan_idx[c]] <= 1'b0;
        end
      end
    end
  end

`ifdef DATA_MEM_CTRL_RR_ARB_EN
  // Round-robin search start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else        rr_ptr <= next_ptr;
  end
`endif

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: directed scenarios on a one-channel instance,
// directed plus randomized traffic on a two-channel instance.
module tb_data_mem_controller;

  logic clk = 1'b0;
  logic reset;

  // one-channel instance
  logic [3:0]  rv, rr, wv, wr;
  logic [31:0] ra, rd, wa, wd;
  logic [0:0]  mrv, mrr, mwv, mwr;
  logic [7:0]  mra, mrd, mwa, mwd;

  // two-channel instance
  logic [3:0]  b_rv, b_rr, b_wv, b_wr;
  logic [31:0] b_ra, b_rd, b_wa, b_wd;
  logic [1:0]  b_mrv, b_mrr, b_mwv, b_mwr;
  logic [15:0] b_mra, b_mrd, b_mwa, b_mwd;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] ext_mem [256];
  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;

  data_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rr), .consumer_read_data(rd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(wr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  data_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  task automatic clear_inputs();
    rv = '0; ra = '0; wv = '0; wa = '0; wd = '0; mrr = '0; mrd = '0; mwr = '0;
    b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0; b_mrr = '0; b_mrd = '0; b_mwr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    vectors++;
    if ({rr, wr, rd, mrv, mra, mwv, mwa, mwd} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: outputs=%h expected all zero", {rr, wr, rd, mrv, mra, mwv, mwa, mwd});
    end
    vectors++;
    if ({b_rr, b_wr, b_rd, b_mrv, b_mra, b_mwv, b_mwa, b_mwd} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: outputs=%h expected all zero", {b_rr, b_wr, b_rd, b_mrv, b_mra, b_mwv, b_mwa, b_mwd});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    rv[1] = 1'b1; ra[15:8] = 8'h3C;
    @(negedge clk);
    vectors++;
    if (mrv !== 1'b1 || mra !== 8'h3C || rr !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_read_req: mrv=%b addr=%h rr=%b expected 1/3c/0000", mrv, mra, rr);
    end
    @(negedge clk);
    mrr = 1'b1; mrd = 8'hA5;
    @(negedge clk);
    mrr = 1'b0; mrd = 8'h00;
    vectors++;
    if (rr !== 4'b0010 || rd[15:8] !== 8'hA5 || mrv !== 1'b0) begin
      miscompares++;
      $display("FAIL single_read_ack: rr=%b data=%h mrv=%b expected 0010/a5/0", rr, rd[15:8], mrv);
    end
    rv[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (rr !== 4'b0000 || rd[15:8] !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_read_drop: rr=%b data=%h expected 0000/a5", rr, rd[15:8]);
    end
  endtask

  task automatic test_single_write();
    wv[2] = 1'b1; wa[23:16] = 8'h10; wd[23:16] = 8'h7E;
    @(negedge clk);
    vectors++;
    if (mwv !== 1'b1 || mwa !== 8'h10 || mwd !== 8'h7E || mrv !== 1'b0) begin
      miscompares++;
      $display("FAIL single_write_req: mwv=%b addr=%h data=%h mrv=%b expected 1/10/7e/0", mwv, mwa, mwd, mrv);
    end
    mwr = 1'b1;
    @(negedge clk);
    mwr = 1'b0;
    vectors++;
    if (wr !== 4'b0100 || mwv !== 1'b0 || rr !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_write_ack: wr=%b mwv=%b rr=%b expected 0100/0/0000", wr, mwv, rr);
    end
    wv[2] = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_write_drop: wr=%b expected 0000", wr);
    end
    // immediate re-request shows the serving bit is already clear
    wv[2] = 1'b1; wa[23:16] = 8'h11; wd[23:16] = 8'h3D;
    @(negedge clk);
    vectors++;
    if (mwv !== 1'b1 || mwa !== 8'h11 || mwd !== 8'h3D) begin
      miscompares++;
      $display("FAIL write_regrant: mwv=%b addr=%h data=%h expected 1/11/3d", mwv, mwa, mwd);
    end
    mwr = 1'b1;
    @(negedge clk);
    mwr = 1'b0; wv[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int first, second;
    logic [7:0] a [4];
    a[0] = 8'h01; a[3] = 8'hC3; a[1] = 8'h00; a[2] = 8'h00;
`ifdef DATA_MEM_CTRL_RR_ARB_EN
    first = 3; second = 0;
`else
    first = 0; second = 3;
`endif
    rv[0] = 1'b1; ra[7:0] = a[0];
    rv[3] = 1'b1; ra[31:24] = a[3];
    for (int n = 0; n < 2; n++) begin
      int who;
      who = (n == 0) ? first : second;
      @(negedge clk);
      vectors++;
      if (mrv !== 1'b1 || mra !== a[who]) begin
        miscompares++;
        $display("FAIL contention_order%0d: mrv=%b addr=%h expected 1/%h", n, mrv, mra, a[who]);
      end
      mrr = 1'b1; mrd = 8'h50 + 8'(who);
      @(negedge clk);
      mrr = 1'b0;
      vectors++;
      if (rr !== 4'(1 << who) || rd[who*8 +: 8] !== 8'h50 + 8'(who)) begin
        miscompares++;
        $display("FAIL contention_ack%0d: rr=%b data=%h expected %b/%h", n, rr, rd[who*8 +: 8], 4'(1 << who), 8'h50 + 8'(who));
      end
      rv[who] = 1'b0;
      @(negedge clk);
      vectors++;
      if (rr !== 4'b0000) begin
        miscompares++;
        $display("FAIL contention_drop%0d: rr=%b expected 0000", n, rr);
      end
    end
  endtask

  task automatic test_hold_valid();
    rv[1] = 1'b1; ra[15:8] = 8'h05;
    @(negedge clk);
    mrr = 1'b1; mrd = 8'h77;
    @(negedge clk);
    mrr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rr !== 4'b0010 || rd[15:8] !== 8'h77 || mrv !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_valid_cyc%0d: rr=%b data=%h mrv=%b expected 0010/77/0", i, rr, rd[15:8], mrv);
      end
      @(negedge clk);
    end
    rv[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (rr !== 4'b0000 || mrv !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_valid_drop: rr=%b mrv=%b expected 0000/0", rr, mrv);
    end
  endtask

  task automatic test_async_reset();
    rv[0] = 1'b1; ra[7:0] = 8'h44;
    @(negedge clk);
    vectors++;
    if (mrv !== 1'b1 || mra !== 8'h44) begin
      miscompares++;
      $display("FAIL areset_pre: mrv=%b addr=%h expected 1/44", mrv, mra);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({rr, wr, rd, mrv, mra, mwv, mwa, mwd} !== '0) begin
      miscompares++;
      $display("FAIL areset_now: outputs=%h expected all zero", {rr, wr, rd, mrv, mra, mwv, mwa, mwd});
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    rv[2] = 1'b1; ra[23:16] = 8'h20;
    @(negedge clk);
    vectors++;
    if (mrv !== 1'b1 || mra !== 8'h20) begin
      miscompares++;
      $display("FAIL areset_fresh_req: mrv=%b addr=%h expected 1/20", mrv, mra);
    end
    mrr = 1'b1; mrd = 8'h9C;
    @(negedge clk);
    mrr = 1'b0;
    vectors++;
    if (rr !== 4'b0100 || rd[23:16] !== 8'h9C) begin
      miscompares++;
      $display("FAIL areset_fresh_ack: rr=%b data=%h expected 0100/9c", rr, rd[23:16]);
    end
    rv[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_channel();
    b_rv = 4'b1111; b_ra = {8'hC0, 8'h80, 8'h40, 8'h00};
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      vectors++;
      if (b_mrv !== 2'b11 || b_mra !== {b_ra[p*16+8 +: 8], b_ra[p*16 +: 8]}) begin
        miscompares++;
        $display("FAIL two_chan_grant%0d: mrv=%b addr=%h expected 11/%h", p, b_mrv, b_mra, {b_ra[p*16+8 +: 8], b_ra[p*16 +: 8]});
      end
      b_mrr = 2'b11; b_mrd = {8'hB1 + 8'(2*p), 8'hB0 + 8'(2*p)};
      @(negedge clk);
      b_mrr = 2'b00;
      vectors++;
      if (b_rr !== 4'(2'b11 << (2*p)) || b_rd[p*16 +: 16] !== {8'hB1 + 8'(2*p), 8'hB0 + 8'(2*p)} || b_mrv !== 2'b00) begin
        miscompares++;
        $display("FAIL two_chan_ack%0d: rr=%b data=%h mrv=%b", p, b_rr, b_rd[p*16 +: 16], b_mrv);
      end
      b_rv = b_rv & ~4'(2'b11 << (2*p));
      @(negedge clk);
      vectors++;
      if (b_rr !== 4'b0000) begin
        miscompares++;
        $display("FAIL two_chan_drop%0d: rr=%b expected 0000", p, b_rr);
      end
    end
  endtask

  task automatic test_random();
    int         cst [4];
    bit         op_rd [4];
    logic [7:0] caddr [4];
    logic [7:0] cdata [4];
    int         wcnt [4];
    int         mcnt [2];
    bit         mact [2];
    bit         rdy, all_idle;
    logic [1:0] own0, own1;
    for (int a = 0; a < 256; a++) begin
      ext_mem[a] = 8'(a) ^ 8'h5A;
      ref_mem[a] = 8'(a) ^ 8'h5A;
    end
    for (int j = 0; j < 4; j++) begin cst[j] = 0; op_rd[j] = 0; caddr[j] = '0; cdata[j] = '0; wcnt[j] = 0; end
    for (int c = 0; c < 2; c++) begin mcnt[c] = 0; mact[c] = 0; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // external memory with random latency
      for (int c = 0; c < 2; c++) begin
        if (b_mrr[c] || b_mwr[c]) begin
          b_mrr[c] = 1'b0; b_mwr[c] = 1'b0;
        end else if (b_mrv[c] || b_mwv[c]) begin
          if (!mact[c]) begin mact[c] = 1; mcnt[c] = int'($urandom_range(0, 3)); end
          if (mcnt[c] == 0) begin
            mact[c] = 0;
            if (b_mrv[c]) begin
              b_mrr[c] = 1'b1; b_mrd[c*8 +: 8] = ext_mem[b_mra[c*8 +: 8]];
            end else begin
              b_mwr[c] = 1'b1; ext_mem[b_mwa[c*8 +: 8]] = b_mwd[c*8 +: 8];
            end
          end else mcnt[c]--;
        end
      end
      // address top bits identify the owning core: two busy channels must serve different cores
      if ((b_mrv[0] || b_mwv[0]) && (b_mrv[1] || b_mwv[1])) begin
        own0 = b_mrv[0] ? b_mra[7:6] : b_mwa[7:6];
        own1 = b_mrv[1] ? b_mra[15:14] : b_mwa[15:14];
        vectors++;
        if (own0 === own1) begin
          miscompares++;
          $display("FAIL rand_dual_service: both channels serving core %0d", own0);
        end
      end
      // cores
      for (int j = 0; j < 4; j++) begin
        rdy = op_rd[j] ? b_rr[j] : b_wr[j];
        case (cst[j])
          0: if (cyc < 3000 && $urandom_range(0, 2) == 0) begin
            op_rd[j] = 1'($urandom_range(0, 1));
            caddr[j] = {2'(j), 6'($urandom)};
            cdata[j] = 8'($urandom);
            wcnt[j]  = 0;
            if (op_rd[j]) begin b_rv[j] = 1'b1; b_ra[j*8 +: 8] = caddr[j]; end
            else begin b_wv[j] = 1'b1; b_wa[j*8 +: 8] = caddr[j]; b_wd[j*8 +: 8] = cdata[j]; end
            cst[j] = 1;
          end
          1: if (rdy) begin
            vectors++;
            if (op_rd[j]) begin
              if (b_rd[j*8 +: 8] !== ref_mem[caddr[j]]) begin
                miscompares++;
                $display("FAIL rand_read core%0d addr=%h: got %h expected %h", j, caddr[j], b_rd[j*8 +: 8], ref_mem[caddr[j]]);
              end
            end else begin
              ref_mem[caddr[j]] = cdata[j];
              if (ext_mem[caddr[j]] !== cdata[j]) begin
                miscompares++;
                $display("FAIL rand_write core%0d addr=%h: memory %h expected %h", j, caddr[j], ext_mem[caddr[j]], cdata[j]);
              end
            end
            b_rv[j] = 1'b0; b_wv[j] = 1'b0;
            cst[j] = 2;
          end else begin
            wcnt[j]++;
            if (wcnt[j] > 200) begin
              vectors++; miscompares++;
              $display("FAIL rand_timeout core%0d: no ready after %0d cycles", j, wcnt[j]);
              b_rv[j] = 1'b0; b_wv[j] = 1'b0;
              cst[j] = 2;
            end
          end
          default: begin
            vectors++;
            if (rdy !== 1'b0) begin
              miscompares++;
              $display("FAIL rand_ready_drop core%0d: ready=%b expected 0", j, rdy);
            end
            cst[j] = 0;
          end
        endcase
      end
      all_idle = 1'b1;
      for (int j = 0; j < 4; j++) if (cst[j] != 0) all_idle = 1'b0;
      if (cyc >= 3000 && all_idle) break;
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (cst[j] != 0) begin
        miscompares++;
        $display("FAIL rand_drain core%0d: still in phase %0d expected 0", j, cst[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_hold_valid();
    test_async_reset();
    test_two_channel();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
